// File: rtl/row_argmax_sequencer.sv
// Issues begin_mult once per row, captures each row_result from the multiplier,
// and reports the index and value of the signed maximum (lowest index wins ties).
module row_argmax_sequencer #(
    parameter int NUM_ROWS       = 10,
    parameter int RESULT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    output logic [3:0]              row_select,
    output logic                    begin_mult,
    input  logic                    done_row,
    input  logic                    w_result_ena,
    input  logic [RESULT_WIDTH-1:0] row_result,
    input  logic                    overflow,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              digit,
    output logic [RESULT_WIDTH-1:0] max_value,
    output logic                    any_overflow,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]        LAST_ROW = 4'(NUM_ROWS - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_nx;
    logic [WD_W-1:0]         wdog;
    logic [RESULT_WIDTH-1:0] cap_value;
    logic                    cap_flag;
    logic                    first_valid;
    logic                    wd_expire;
    logic                    new_winner;

    always_comb begin
        state_nx   = state;
        begin_mult = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        wd_expire  = 1'b0;
        new_winner = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                begin_mult = 1'b1;
                busy       = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // done_row on the final watchdog cycle still completes the row
                if (done_row) begin
                    state_nx = S_NEXT;
                end else if (wdog == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_NEXT: begin
                busy       = 1'b1;
                new_winner = cap_flag &&
                             (!first_valid || ($signed(cap_value) > $signed(max_value)));
                state_nx   = (row_select == LAST_ROW) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_select   <= '0;
            digit        <= '0;
            max_value    <= '0;
            any_overflow <= 1'b0;
            err          <= 1'b0;
            cap_value    <= '0;
            cap_flag     <= 1'b0;
            first_valid  <= 1'b0;
            wdog         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_select   <= '0;
                        digit        <= '0;
                        max_value    <= '0;
                        any_overflow <= 1'b0;
                        err          <= 1'b0;
                        cap_flag     <= 1'b0;
                        first_valid  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    wdog <= '0;
                end
                S_WAIT: begin
                    if (w_result_ena) begin
                        cap_value <= row_result;
                        cap_flag  <= 1'b1;
                        if (overflow) any_overflow <= 1'b1;
                    end
                    if (wd_expire)     err  <= 1'b1;
                    else if (!done_row) wdog <= wdog + WD_W'(1);
                end
                S_NEXT: begin
                    if (new_winner) begin
                        digit       <= row_select;
                        max_value   <= cap_value;
                        first_valid <= 1'b1;
                    end
                    if (!cap_flag) err <= 1'b1;
                    cap_flag <= 1'b0;
                    if (row_select != LAST_ROW) row_select <= row_select + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_argmax_sequencer.sv
// Randomized bench for row_argmax_sequencer: a cycle-level multiplier responder
// plus an argmax reference model built from per-row outcome tables.
module tb_row_argmax_sequencer;

    localparam int NR = 10;
    localparam int RW = 32;
    localparam int TO = 4096;

    localparam int M_NORMAL  = 0;
    localparam int M_DOUBLE  = 1;
    localparam int M_MISSING = 2;
    localparam int M_SILENT  = 3;
    localparam int M_EARLY   = 4;

    logic          tb_clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          done_row = 1'b0;
    logic          w_result_ena = 1'b0;
    logic          overflow = 1'b0;
    logic [RW-1:0] row_result = '0;
    logic [3:0]    row_select, digit;
    logic          begin_mult, busy, done, any_overflow, err;
    logic [RW-1:0] max_value;

    int n_tests = 0;
    int n_fail  = 0;

    int row_val [NR];
    bit row_ovf [NR];
    int row_mode[NR];
    int row_dly [NR];

    always #5 tb_clk = ~tb_clk;

    row_argmax_sequencer #(
        .NUM_ROWS      (NR),
        .RESULT_WIDTH  (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .start       (start),
        .row_select  (row_select),
        .begin_mult  (begin_mult),
        .done_row    (done_row),
        .w_result_ena(w_result_ena),
        .row_result  (row_result),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done),
        .digit       (digit),
        .max_value   (max_value),
        .any_overflow(any_overflow),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outcome of a run derived from the row tables: a silent row ends the run,
    // a missing row flags err, the winner is the first row holding the largest value.
    function automatic void ref_model(output int e_digit, output int e_max, output bit e_err,
                                      output bit e_ovf, output int e_issues, output int silent_row);
        bit valid[NR];
        int last;
        bit found;
        e_err = 0; e_ovf = 0; silent_row = -1; last = NR - 1;
        for (int i = 0; i < NR; i++) valid[i] = 0;
        for (int i = 0; i < NR; i++)
            if (row_mode[i] == M_SILENT) begin
                silent_row = i; last = i; e_err = 1; break;
            end
        for (int i = 0; i <= last; i++) begin
            if (row_mode[i] == M_MISSING) e_err = 1;
            else if (row_mode[i] != M_SILENT) begin
                valid[i] = 1;
                if (row_ovf[i]) e_ovf = 1;
            end
        end
        e_issues = last + 1;
        found = 0; e_max = 0; e_digit = 0;
        for (int i = 0; i <= last; i++)
            if (valid[i] && (!found || row_val[i] > e_max)) begin
                e_max = row_val[i]; found = 1;
            end
        for (int i = last; i >= 0; i--)
            if (valid[i] && row_val[i] == e_max) e_digit = i;
    endfunction

    task automatic fill_rows(input int val, input int mode, input int dly);
        for (int i = 0; i < NR; i++) begin
            row_val[i] = val; row_ovf[i] = 0; row_mode[i] = mode; row_dly[i] = dly;
        end
    endtask

    function automatic int rand_val();
        if ($urandom_range(1) == 0) return int'($urandom_range(6)) - 3;
        return int'($urandom);
    endfunction

    task automatic randomize_rows(input bit allow_silent);
        for (int i = 0; i < NR; i++) begin
            int r;
            row_val[i] = rand_val();
            row_ovf[i] = ($urandom_range(5) == 0);
            row_dly[i] = int'($urandom_range(1, 6));
            r = int'($urandom_range(9));
            row_mode[i] = (r < 5) ? M_NORMAL : (r < 7) ? M_DOUBLE : (r < 8) ? M_MISSING : M_EARLY;
        end
        if (allow_silent) row_mode[$urandom_range(NR - 1)] = M_SILENT;
    endtask

    // Entered and left at posedge+1; inputs for a cycle are set right after its edge.
    task automatic run_case(input string tag, input bit spurious, input int abort_row,
                            input bit restart_mid);
        int  issues = 0, cyc = 0, countdown = 0, cur = -1, done_cyc = -1, abort_at = -1;
        int  issue_cyc[NR];
        bit  pending = 0, busy_ok = 1;
        int  e_digit, e_max, e_issues, silent_row;
        bit  e_err, e_ovf;
        logic [RW-1:0] e_max_u;

        for (int i = 0; i < NR; i++) issue_cyc[i] = 0;
        start = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        while (cyc < 6000) begin
            done_row = 1'b0; w_result_ena = 1'b0; row_result = $urandom;
            overflow = spurious && ($urandom_range(7) == 0);
            start    = restart_mid && (cyc == 5);
            if (cyc == abort_at) begin
                #2 n_rst = 1'b0;
                #1;
                check_eq({tag, ".rst_outputs"},
                         {row_select, begin_mult, busy, done, digit, max_value, any_overflow, err}, '0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge tb_clk); #1;
                    if (done) busy_ok = 0;
                end
                check_eq({tag, ".no_done_in_reset"}, busy_ok, 1);
                #2 n_rst = 1'b1;
                @(posedge tb_clk); #1;
                check_eq({tag, ".idle_after_reset"}, {busy, done, begin_mult}, 0);
                return;
            end
            if (done) begin
                done_cyc = cyc;
                check_eq({tag, ".busy_at_done"}, busy, 0);
                if (restart_mid) start = 1'b1;
                if (spurious) begin done_row = 1'b1; w_result_ena = 1'b1; row_result = 32'h7fffffff; end
                break;
            end
            if (!busy) busy_ok = 0;
            if (begin_mult) begin
                if (issues < NR) issue_cyc[issues] = cyc;
                check_eq({tag, ".row_select"}, row_select, issues);
                cur = issues; issues++;
                pending = 1;
                countdown = row_dly[cur];
                if ((row_mode[cur] == M_DOUBLE || row_mode[cur] == M_EARLY) && countdown < 2) countdown = 2;
                if (cur == abort_row) abort_at = cyc + 2;
                if (spurious && $urandom_range(3) == 0) begin
                    done_row = 1'b1; w_result_ena = 1'b1; row_result = 32'h7fffffff; overflow = 1'b1;
                end
            end else if (pending) begin
                countdown--;
                case (row_mode[cur])
                    M_NORMAL: if (countdown == 0) begin
                        w_result_ena = 1'b1; row_result = row_val[cur]; overflow = row_ovf[cur];
                        done_row = 1'b1; pending = 0;
                    end
                    M_DOUBLE: if (countdown == 1) begin
                        w_result_ena = 1'b1; row_result = 32'h7ffffffe; overflow = 1'b0;
                    end else if (countdown == 0) begin
                        w_result_ena = 1'b1; row_result = row_val[cur]; overflow = row_ovf[cur];
                        done_row = 1'b1; pending = 0;
                    end
                    M_MISSING: if (countdown == 0) begin
                        done_row = 1'b1; overflow = 1'b0; pending = 0;
                    end
                    M_EARLY: if (countdown == 1) begin
                        w_result_ena = 1'b1; row_result = row_val[cur]; overflow = row_ovf[cur];
                    end else if (countdown == 0) begin
                        done_row = 1'b1; overflow = 1'b0; pending = 0;
                    end
                    default: ;
                endcase
            end
            @(posedge tb_clk); #1;
            cyc++;
        end

        if (done_cyc < 0) begin
            check_eq({tag, ".done_seen"}, 0, 1);
            return;
        end
        ref_model(e_digit, e_max, e_err, e_ovf, e_issues, silent_row);
        e_max_u = e_max;
        check_eq({tag, ".digit"}, digit, e_digit);
        check_eq({tag, ".max_value"}, max_value, e_max_u);
        check_eq({tag, ".err"}, err, e_err);
        check_eq({tag, ".any_overflow"}, any_overflow, e_ovf);
        check_eq({tag, ".issues"}, issues, e_issues);
        check_eq({tag, ".busy_during_run"}, busy_ok, 1);
        if (silent_row >= 0)
            check_eq({tag, ".timeout_latency"}, done_cyc - issue_cyc[silent_row], TO + 1);

        @(posedge tb_clk); #1;
        start = 1'b0; done_row = 1'b0; w_result_ena = 1'b0; overflow = 1'b0;
        check_eq({tag, ".done_one_cycle"}, {done, busy}, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge tb_clk); #1;
            if (begin_mult || busy || done) busy_ok = 0;
        end
        check_eq({tag, ".stays_idle"}, busy_ok, 1);
        check_eq({tag, ".hold"}, {digit, max_value, any_overflow, err},
                 {4'(e_digit), e_max_u, e_ovf, e_err});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        repeat (3) @(posedge tb_clk);
        #1;
        check_eq("reset.outputs",
                 {row_select, begin_mult, busy, done, digit, max_value, any_overflow, err}, '0);
        n_rst = 1'b1;
        @(posedge tb_clk); #1;
        done_row = 1'b1; w_result_ena = 1'b1; row_result = 32'h1234; overflow = 1'b1;
        @(posedge tb_clk); #1;
        done_row = 1'b0; w_result_ena = 1'b0; overflow = 1'b0;
        check_eq("idle.ignore_inputs", {busy, any_overflow, err, max_value}, '0);

        fill_rows(392, M_NORMAL, 30);
        row_val[3] = 784;
        run_case("basic", 0, -1, 0);

        fill_rows(-5, M_NORMAL, 3);
        row_val[2] = -1; row_val[6] = -1;
        for (int i = 0; i < NR; i++) row_dly[i] = int'($urandom_range(1, 6));
        run_case("neg_tie", 0, -1, 0);

        fill_rows(0, M_NORMAL, 2);
        for (int i = 0; i < NR; i++) row_val[i] = int'($urandom_range(1000));
        row_val[7] = 32'h7fffffff; row_ovf[7] = 1;
        run_case("overflow", 0, -1, 0);

        randomize_rows(0);
        row_mode[4] = M_MISSING; row_val[4] = 32'h7fffffff;
        run_case("missing", 0, -1, 0);

        randomize_rows(0);
        row_mode[5] = M_SILENT;
        run_case("timeout", 0, -1, 0);

        randomize_rows(0);
        row_dly[6] = 20; row_mode[6] = M_NORMAL;
        run_case("abort", 0, 6, 0);
        randomize_rows(0);
        run_case("after_abort", 0, -1, 0);

        randomize_rows(0);
        run_case("restart_mid", 1, -1, 1);

        fill_rows(77, M_MISSING, 2);
        run_case("all_missing", 0, -1, 0);

        for (int r = 0; r < 14; r++) begin
            randomize_rows(r % 7 == 6);
            run_case($sformatf("rand%0d", r), 1, -1, (r % 3) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
